// File: rtl/text_grid_ctl_pkg.sv
// Shared VGA types for the text-grid overlay: widths, grid geometry, FSM states, pixel bundle.
package text_grid_ctl_pkg;

   localparam int RGB_W     = 12;
   localparam int CNT_BITS  = 11;
   localparam int GRID_COLS = 16;
   localparam int GRID_ROWS = 16;
   localparam int GLYPH_W   = 8;
   localparam int GLYPH_H   = 16;
   localparam int BOX_W     = GRID_COLS * GLYPH_W;
   localparam int BOX_H     = GRID_ROWS * GLYPH_H;

   typedef enum logic [1:0] {HIDDEN, SHOW, BLINK_ON, BLINK_OFF} grid_state_t;

   typedef struct packed {
      logic [CNT_BITS-1:0] hcount;
      logic [CNT_BITS-1:0] vcount;
      logic                hsync;
      logic                vsync;
      logic                hblnk;
      logic                vblnk;
      logic [RGB_W-1:0]    rgb;
   } vga_t;

endpackage

// File: rtl/text_grid_ctl_delay.sv
// N-stage delay line for the VGA timing/count/rgb bundle; latency N pclk.
// No backpressure: the pixel stream is free-running.
module vga_delay
   import text_grid_ctl_pkg::*;
#(
   parameter int N = 3
) (
   input  logic pclk,
   input  logic rst,
   input  vga_t d,
   output vga_t q
);
   vga_t pipe [N];

   always_ff @(posedge pclk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N; i++) pipe[i] <= '0;
      end else begin
         pipe[0] <= d;
         for (int i = 1; i < N; i++) pipe[i] <= pipe[i-1];
      end
   end

   assign q = pipe[N-1];

endmodule

// File: rtl/text_grid_ctl.sv
// Overlays a 16x16 text grid on the VGA stream via char/font ROMs; latency 3 pclk.
// No backpressure: one pixel in and one pixel out every pclk.
module text_grid_ctl
   import text_grid_ctl_pkg::*;
#(
   parameter logic [RGB_W-1:0] TEXT_COLOR   = 12'hFFF,
   parameter int               BLINK_FRAMES = 30,
   parameter int               CNT_W        = 6
) (
   input  logic                pclk,
   input  logic                rst,
   input  logic [CNT_BITS-1:0] hcount_in,
   input  logic [CNT_BITS-1:0] vcount_in,
   input  logic                hsync_in,
   input  logic                vsync_in,
   input  logic                hblnk_in,
   input  logic                vblnk_in,
   input  logic [RGB_W-1:0]    rgb_in,
   input  logic [CNT_BITS-1:0] box_x,
   input  logic [CNT_BITS-1:0] box_y,
   input  logic                text_en,
   input  logic                blink_en,
   output logic [7:0]          char_xy,
   output logic [3:0]          char_line,
   input  logic [7:0]          char_pixels,
   output logic [CNT_BITS-1:0] hcount_out,
   output logic [CNT_BITS-1:0] vcount_out,
   output logic                hsync_out,
   output logic                vsync_out,
   output logic                hblnk_out,
   output logic                vblnk_out,
   output logic [RGB_W-1:0]    rgb_out
);
   logic [CNT_BITS-1:0] box_xl, box_yl, rel_x, rel_y;
   logic                vblnk_prev, frame_evt, in_box, show;
   grid_state_t         state, state_nxt;
   logic [CNT_W-1:0]    cnt, cnt_nxt;
   logic [2:0]          col1, col2;
   logic                in1, in2, txt3;
   vga_t                stage_in, stage_out;

   assign frame_evt = vblnk_in & ~vblnk_prev;

   // Box position only moves at the start of vertical blank so a frame never tears.
   always_ff @(posedge pclk or posedge rst) begin
      if (rst) begin
         vblnk_prev <= 1'b0;
         box_xl     <= '0;
         box_yl     <= '0;
      end else begin
         vblnk_prev <= vblnk_in;
         if (frame_evt) begin
            box_xl <= box_x;
            box_yl <= box_y;
         end
      end
   end

   always_ff @(posedge pclk or posedge rst) begin
      if (rst) begin
         state <= HIDDEN;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      if (frame_evt) begin
         unique case (state)
            HIDDEN: if (text_en) begin
               state_nxt = blink_en ? BLINK_ON : SHOW;
               cnt_nxt   = '0;
            end
            SHOW: if (!text_en) begin
               state_nxt = HIDDEN;
            end else if (blink_en) begin
               state_nxt = BLINK_ON;
               cnt_nxt   = '0;
            end
            BLINK_ON, BLINK_OFF: if (!text_en) begin
               state_nxt = HIDDEN;
            end else if (!blink_en) begin
               state_nxt = SHOW;
            end else if (cnt == CNT_W'(BLINK_FRAMES - 1)) begin
               state_nxt = (state == BLINK_ON) ? BLINK_OFF : BLINK_ON;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
            default: state_nxt = HIDDEN;
         endcase
      end
   end

   always_comb begin
      show = (state == SHOW) || (state == BLINK_ON);
   end

   assign rel_x  = hcount_in - box_xl;
   assign rel_y  = vcount_in - box_yl;
   assign in_box = (hcount_in >= box_xl) && (rel_x < CNT_BITS'(BOX_W)) &&
                   (vcount_in >= box_yl) && (rel_y < CNT_BITS'(BOX_H));

   // Blanking is folded into the in-box flag early; it is the same pixel's blanking two stages on.
   always_ff @(posedge pclk or posedge rst) begin
      if (rst) begin
         char_xy   <= '0;
         char_line <= '0;
         col1      <= '0;
         in1       <= 1'b0;
         col2      <= '0;
         in2       <= 1'b0;
         txt3      <= 1'b0;
      end else begin
         char_xy   <= {rel_y[7:4], rel_x[6:3]};
         char_line <= rel_y[3:0];
         col1      <= rel_x[2:0];
         in1       <= in_box & ~hblnk_in & ~vblnk_in;
         col2      <= col1;
         in2       <= in1;
         txt3      <= show & in2 & char_pixels[3'd7 - col2];
      end
   end

   assign stage_in = '{hcount: hcount_in, vcount: vcount_in, hsync: hsync_in,
                       vsync: vsync_in, hblnk: hblnk_in, vblnk: vblnk_in, rgb: rgb_in};

   vga_delay #(.N(3)) u_delay (
      .pclk (pclk),
      .rst  (rst),
      .d    (stage_in),
      .q    (stage_out)
   );

   assign hcount_out = stage_out.hcount;
   assign vcount_out = stage_out.vcount;
   assign hsync_out  = stage_out.hsync;
   assign vsync_out  = stage_out.vsync;
   assign hblnk_out  = stage_out.hblnk;
   assign vblnk_out  = stage_out.vblnk;
   assign rgb_out    = txt3 ? TEXT_COLOR : stage_out.rgb;

endmodule
